instr_decode: RTL and testbench
===============================

// Module: instr_decode
// PURPOSE
//  RV32I instruction-decode stage: splits a 32-bit instruction into fields, generates the sign-extended immediate,
//  and holds the 32x32 integer register file. Two read ports serve the decoded rs1/rs2; one write port serves writeback.
//  Sits between the IF stage (Instr) and the EX stage (operands, imm, control fields).
// PARAMETERS
//  XLEN     32  data/register width
//  NREGS    32  number of architectural registers (index width = $clog2(NREGS) = 5)
// PORTS
//  clk        in   1     clock, all state updates on rising edge
//  rst        in   1     synchronous, active-high reset
//  RegWrite   in   1     writeback enable
//  Instr      in   32    instruction word to decode
//  WriteData  in   XLEN  writeback data
//  WriteReg   in   5     writeback destination index
//  ReadData1  out  XLEN  value of register rs1
//  ReadData2  out  XLEN  value of register rs2
//  imm        out  32    sign-extended immediate
//  rs1        out  5     Instr[19:15]
//  rs2        out  5     Instr[24:20]
//  rd         out  5     Instr[11:7]
//  opcode     out  7     Instr[6:0]
//  funct3     out  3     Instr[14:12]
//  funct7     out  7     Instr[31:25]
// BEHAVIOUR
//  - One clock domain (clk); reset is synchronous and active-high (rst).
//  - Field outputs are pure combinational slices of Instr. They are always driven, regardless of format or reset.
//  - imm is combinational and selected by opcode:
//      I  (0010011, 0000011, 1100111): {{20{I[31]}}, I[31:20]}
//      S  (0100011): {{20{I[31]}}, I[31:25], I[11:7]}
//      B  (1100011): {{19{I[31]}}, I[31], I[7], I[30:25], I[11:8], 1'b0}
//      U  (0110111, 0010111): {I[31:12], 12'b0}
//      J  (1101111): {{11{I[31]}}, I[31], I[19:12], I[20], I[30:21], 1'b0}
//      R-type and any other opcode: 32'h0
//  - Register file read is asynchronous: ReadData1 = x[rs1], ReadData2 = x[rs2].
//    Reading index 0 always returns 0.
//  - Write: on posedge clk with !rst, if RegWrite && WriteReg != 0, then x[WriteReg] <= WriteData.
//    A write to x0 is discarded.
//  - Reset: on posedge clk with rst=1, all registers clear to 0. Reset has priority over a simultaneous write,
//    so a write in a reset cycle is lost. After reset, both read ports return 0.
//  - Same-cycle write and read of the same register: without the bypass (see CONFIGURATION), the read returns
//    the old value until the edge.
//  - X on Instr propagates to the fields and imm only. It never corrupts register state.
// CONFIGURATION
//  ID_BYPASS_EN defined: write-through forwarding. If RegWrite && WriteReg != 0 && WriteReg == rs1 (resp. rs2),
//    ReadData1 (resp. ReadData2) = WriteData combinationally in the same cycle. Never active for x0, and not active
//    while rst=1.
//  ID_BYPASS_EN undefined: plain register read; the new value is visible only after the write edge.
// STRUCTURE
//  - Shared package: opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI,
//    OP_AUIPC), XLEN, and the REG_IDX_W = 5 constant.
//  - Sub-module regfile (2R/1W, x0 hardwired, sync reset, optional bypass).
//  - Top level holds field slicing and the imm mux.
// TESTING
//  1. rst=1 for one edge, then read rs1=2, rs2=3 -> ReadData1 = ReadData2 = 0.
//  2. Instr = 32'h003100B3 (ADD x1,x2,x3) -> opcode=0110011, rd=1, rs1=2, rs2=3, funct3=0, funct7=0, imm=0.
//  3. Instr = 32'h00510093 (ADDI x1,x2,5) -> opcode=0010011, imm=32'h5; Instr = 32'hFFF10093 -> imm=32'hFFFFFFFF.
//  4. Instr = 32'h002080E3 (BEQ, only bit 7 set in the imm fields) -> rs1=1, rs2=2, imm=32'h00000800.
//     Instr = 32'hFFFFF0B7 (LUI x1) -> imm=32'hFFFFF000.
//  5. RegWrite=1, WriteReg=5, WriteData=32'hDEADBEEF, edge; then Instr with rs1=5 -> ReadData1 = 32'hDEADBEEF.
//     Write to WriteReg=0 -> x0 still reads 0.
//  6. Write reg 7 = 32'h1234 with rst=1 in the same cycle -> reg 7 reads 0.
//     With ID_BYPASS_EN, a same-cycle write to rs2 -> ReadData2 = WriteData before the edge.

Source files
------------

// File: rtl/instr_decode_pkg.sv
// Shared RV32I decode constants: data width, register index width and base opcodes.
package instr_decode_pkg;

   localparam int XLEN      = 32;
   localparam int NREGS     = 32;
   localparam int REG_IDX_W = $clog2(NREGS);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/instr_decode_regfile.sv
// 32x32 register file, 2 async reads / 1 sync write, x0 hardwired to zero, sync active-high reset.
// Define ID_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module instr_decode_regfile
   import instr_decode_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_we,
   input  logic [REG_IDX_W-1:0] i_waddr,
   input  logic [XLEN-1:0]      i_wdata,
   input  logic [REG_IDX_W-1:0] i_raddr1,
   input  logic [REG_IDX_W-1:0] i_raddr2,
   output logic [XLEN-1:0]      o_rdata1,
   output logic [XLEN-1:0]      o_rdata2
);

   logic [XLEN-1:0] r_regs [NREGS];

   // Reset wins over a write in the same cycle; writes to x0 are dropped.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we && (i_waddr != '0)) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   always_comb begin
      o_rdata1 = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
      o_rdata2 = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];
`ifdef ID_BYPASS_EN
      if (!i_rst && i_we && (i_waddr != '0) && (i_waddr == i_raddr1)) begin
         o_rdata1 = i_wdata;
      end
      if (!i_rst && i_we && (i_waddr != '0) && (i_waddr == i_raddr2)) begin
         o_rdata2 = i_wdata;
      end
`endif
   end

endmodule

// File: rtl/instr_decode.sv
// RV32I decode stage: field slicing, sign-extended immediate and the integer register file.
// Optional write-through forwarding is enabled with ID_BYPASS_EN.
module instr_decode
   import instr_decode_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 RegWrite,
   input  logic [31:0]          Instr,
   input  logic [XLEN-1:0]      WriteData,
   input  logic [REG_IDX_W-1:0] WriteReg,
   output logic [XLEN-1:0]      ReadData1,
   output logic [XLEN-1:0]      ReadData2,
   output logic [31:0]          imm,
   output logic [REG_IDX_W-1:0] rs1,
   output logic [REG_IDX_W-1:0] rs2,
   output logic [REG_IDX_W-1:0] rd,
   output logic [6:0]           opcode,
   output logic [2:0]           funct3,
   output logic [6:0]           funct7
);

   logic [6:0] w_opcode;

   assign w_opcode = Instr[6:0];
   assign opcode   = w_opcode;
   assign rd       = Instr[11:7];
   assign funct3   = Instr[14:12];
   assign rs1      = Instr[19:15];
   assign rs2      = Instr[24:20];
   assign funct7   = Instr[31:25];

   always_comb begin
      imm = 32'h0;
      case (w_opcode)
         OP_IMM, OP_LOAD, OP_JALR:
            imm = {{20{Instr[31]}}, Instr[31:20]};
         OP_STORE:
            imm = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
         OP_BRANCH:
            imm = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
         OP_LUI, OP_AUIPC:
            imm = {Instr[31:12], 12'b0};
         OP_JAL:
            imm = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0};
         default:
            imm = 32'h0;
      endcase
   end

   instr_decode_regfile u_regfile (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_we     (RegWrite),
      .i_waddr  (WriteReg),
      .i_wdata  (WriteData),
      .i_raddr1 (Instr[19:15]),
      .i_raddr2 (Instr[24:20]),
      .o_rdata1 (ReadData1),
      .o_rdata2 (ReadData2)
   );

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode: directed cases plus randomized traffic against a behavioural model.
module tb_instr_decode;

   logic        clk = 1'b0;
   logic        rst;
   logic        RegWrite;
   logic [31:0] Instr;
   logic [31:0] WriteData;
   logic [4:0]  WriteReg;
   logic [31:0] ReadData1, ReadData2, imm;
   logic [4:0]  rs1, rs2, rd;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] model [32];
   logic [6:0]  ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                              7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0001111};

   always #5 clk = ~clk;

   instr_decode dut (
      .clk       (clk),
      .rst       (rst),
      .RegWrite  (RegWrite),
      .Instr     (Instr),
      .WriteData (WriteData),
      .WriteReg  (WriteReg),
      .ReadData1 (ReadData1),
      .ReadData2 (ReadData2),
      .imm       (imm),
      .rs1       (rs1),
      .rs2       (rs2),
      .rd        (rd),
      .opcode    (opcode),
      .funct3    (funct3),
      .funct7    (funct7)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Immediate as the signed byte offset / value the instruction format encodes.
   function automatic logic [31:0] ref_imm(input logic [31:0] i);
      int v;
      v = 0;
      case (i[6:0])
         7'b0010011, 7'b0000011, 7'b1100111: v = int'($signed(i[31:20]));
         7'b0100011: v = int'($signed({i[31:25], i[11:7]}));
         7'b1100011: v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048
                         + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
         7'b0110111, 7'b0010111: v = int'(i[31:12]) * 4096;
         7'b1101111: v = (i[31] ? -(1 << 20) : 0) + int'(i[19:12]) * 4096
                         + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
         default: v = 0;
      endcase
      return 32'(v);
   endfunction

   function automatic logic [31:0] ref_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'h0;
`ifdef ID_BYPASS_EN
      if (!rst && RegWrite && WriteReg == idx) return WriteData;
`endif
      return model[idx];
   endfunction

   function automatic logic [31:0] mk_r(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
      return {7'b0, s2, s1, 3'b0, d, 7'b0110011};
   endfunction

   // Advance one edge, mirroring the architectural effect into the model.
   task automatic step();
      @(posedge clk);
      if (rst) begin
         for (int k = 0; k < 32; k++) model[k] = 32'h0;
      end else if (RegWrite && WriteReg != 5'd0) begin
         model[WriteReg] = WriteData;
      end
      #1;
   endtask

   task automatic check_all(input string tag);
      check_eq({tag, ".opcode"}, 32'(opcode), 32'(Instr[6:0]));
      check_eq({tag, ".rd"},     32'(rd),     32'(Instr[11:7]));
      check_eq({tag, ".funct3"}, 32'(funct3), 32'(Instr[14:12]));
      check_eq({tag, ".rs1"},    32'(rs1),    32'(Instr[19:15]));
      check_eq({tag, ".rs2"},    32'(rs2),    32'(Instr[24:20]));
      check_eq({tag, ".funct7"}, 32'(funct7), 32'(Instr[31:25]));
      check_eq({tag, ".imm"},    imm,         ref_imm(Instr));
      check_eq({tag, ".rd1"},    ReadData1,   ref_read(Instr[19:15]));
      check_eq({tag, ".rd2"},    ReadData2,   ref_read(Instr[24:20]));
   endtask

   initial begin
      for (int k = 0; k < 32; k++) model[k] = 32'hFFFF_FFFF;
      rst = 1'b1; RegWrite = 1'b0; WriteData = '0; WriteReg = '0;
      Instr = 32'h003100B3;
      #2;
      step();
      rst = 1'b0;
      #1;
      check_eq("reset.rd1", ReadData1, 32'h0);
      check_eq("reset.rd2", ReadData2, 32'h0);

      // ADD x1,x2,x3
      check_eq("add.opcode", 32'(opcode), 32'h33);
      check_eq("add.rd",     32'(rd),     32'd1);
      check_eq("add.rs1",    32'(rs1),    32'd2);
      check_eq("add.rs2",    32'(rs2),    32'd3);
      check_eq("add.f3",     32'(funct3), 32'd0);
      check_eq("add.f7",     32'(funct7), 32'd0);
      check_eq("add.imm",    imm,         32'h0);

      Instr = 32'h00510093; #1;
      check_eq("addi.opcode", 32'(opcode), 32'h13);
      check_eq("addi.imm",    imm, 32'h5);
      Instr = 32'hFFF10093; #1;
      check_eq("addi_neg.imm", imm, 32'hFFFF_FFFF);
      Instr = 32'h002080E3; #1;
      check_eq("beq.rs1", 32'(rs1), 32'd1);
      check_eq("beq.rs2", 32'(rs2), 32'd2);
      check_eq("beq.imm", imm, 32'h0000_0800);
      Instr = 32'hFFFFF0B7; #1;
      check_eq("lui.imm", imm, 32'hFFFF_F000);

      // Write x5, look at it before and after the edge.
      Instr = mk_r(5'd1, 5'd5, 5'd0);
      RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'hDEADBEEF; #1;
`ifdef ID_BYPASS_EN
      check_eq("wr5.pre", ReadData1, 32'hDEADBEEF);
`else
      check_eq("wr5.pre", ReadData1, 32'h0);
`endif
      step();
      RegWrite = 1'b0; #1;
      check_eq("wr5.post", ReadData1, 32'hDEADBEEF);

      // Writes to x0 are discarded.
      RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'hFFFF_FFFF;
      Instr = mk_r(5'd1, 5'd0, 5'd0); #1;
      check_eq("x0.pre", ReadData1, 32'h0);
      step();
      RegWrite = 1'b0; #1;
      check_eq("x0.post", ReadData1, 32'h0);

      // Reset beats a simultaneous write.
      rst = 1'b1; RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'h1234;
      Instr = mk_r(5'd1, 5'd7, 5'd7); #1;
      check_eq("rstwr.rd2_no_fwd", ReadData2, 32'h0);
      step();
      rst = 1'b0; RegWrite = 1'b0; #1;
      check_eq("rstwr.r7", ReadData1, 32'h0);
      Instr = mk_r(5'd1, 5'd5, 5'd7); #1;
      check_eq("rstwr.r5_cleared", ReadData1, 32'h0);

      // Same-cycle write to rs2.
      RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'hCAFE_F00D;
      Instr = mk_r(5'd1, 5'd0, 5'd9); #1;
`ifdef ID_BYPASS_EN
      check_eq("same.rd2", ReadData2, 32'hCAFE_F00D);
`else
      check_eq("same.rd2", ReadData2, 32'h0);
`endif
      step();
      RegWrite = 1'b0; #1;
      check_eq("same.post", ReadData2, 32'hCAFE_F00D);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         Instr     = $urandom;
         Instr[6:0] = ops[$urandom_range(0, 9)];
         RegWrite  = ($urandom_range(0, 3) != 0);
         WriteReg  = (($urandom_range(0, 2) == 0) ? Instr[19:15] : 5'($urandom));
         WriteData = $urandom;
         rst       = ($urandom_range(0, 40) == 0);
         #1;
         check_all("rand");
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
